// File: rtl/write_ptr.sv
// Write-side pointer and registered full flag for a dual-clock FIFO (write clock domain).
// Pointer and full update on the same edge as the accepting write; writes while full are dropped.
module write_ptr #(
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_SIZE:0]   wr_ptr_2_i,
  input  logic                 inc_i,
  output logic [ADDR_SIZE:0]   ptr_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic                 fifo_full_o
);

  logic [ADDR_SIZE:0] bin;
  logic [ADDR_SIZE:0] bin_next;
  logic [ADDR_SIZE:0] gray_next;
  logic [ADDR_SIZE:0] full_target;
  logic               wr_accept;

  assign wr_accept = inc_i & ~fifo_full_o;
  assign bin_next  = bin + {{ADDR_SIZE{1'b0}}, wr_accept};
  assign gray_next = (bin_next >> 1) ^ bin_next;

  // The writer is a full lap ahead when its Gray pointer equals the read pointer
  // with the two top bits inverted.
  assign full_target = {~wr_ptr_2_i[ADDR_SIZE:ADDR_SIZE-1], wr_ptr_2_i[ADDR_SIZE-2:0]};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bin         <= '0;
      ptr_o       <= '0;
      fifo_full_o <= 1'b0;
    end else begin
      bin         <= bin_next;
      ptr_o       <= gray_next;
      fifo_full_o <= (gray_next == full_target);
    end
  end

  assign addr_o = bin[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_write_ptr.sv
// Scoreboard bench for write_ptr: directed fill/release/wrap/idle/reset sequence, then random traffic.
module tb_write_ptr;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int MOD   = 1 << (AW + 1);

  logic          clk;
  logic          rst;
  logic [AW:0]   rp;
  logic          inc;
  logic [AW:0]   ptr;
  logic [AW-1:0] addr;
  logic          full;

  write_ptr #(.ADDR_SIZE(AW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_ptr_2_i (rp),
    .inc_i      (inc),
    .ptr_o      (ptr),
    .addr_o     (addr),
    .fifo_full_o(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW:0]   ptr;
    logic [AW-1:0] addr;
    logic          full;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: number of accepted writes and the full flag it implies.
  int   m_count = 0;
  bit   m_full  = 1'b0;

  function automatic int gray2bin(input logic [AW:0] g);
    int b = 0;
    for (int i = AW; i >= 0; i--) begin
      b = b | ((((b >> (i + 1)) & 1) ^ int'(g[i])) << i);
    end
    return b;
  endfunction

  function automatic logic [AW:0] bin2gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic step(input logic r, input logic i, input logic [AW:0] p);
    exp_t e;
    @(negedge clk);
    rst = r;
    inc = i;
    rp  = p;
    @(posedge clk);
    if (!r) begin
      m_count = 0;
      m_full  = 1'b0;
    end else begin
      if (i && !m_full) m_count = (m_count + 1) % MOD;
      // Full when writes lead reads by exactly one FIFO depth.
      m_full = (((m_count - gray2bin(p)) % MOD + MOD) % MOD) == DEPTH;
    end
    e.ptr  = bin2gray(m_count);
    e.addr = AW'(m_count % DEPTH);
    e.full = m_full;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (ptr !== e.ptr) begin
        errors++;
        $display("FAIL ptr t=%0t got %b want %b", $time, ptr, e.ptr);
      end
      checks++;
      if (addr !== e.addr) begin
        errors++;
        $display("FAIL addr t=%0t got %b want %b", $time, addr, e.addr);
      end
      checks++;
      if (full !== e.full) begin
        errors++;
        $display("FAIL full t=%0t got %b want %b", $time, full, e.full);
      end
    end
  end

  initial begin
    logic [AW:0] p;
    rst = 1'b1;
    inc = 1'b0;
    rp  = '0;

    step(1'b0, 1'b0, 3'b000);                        // reset
    for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 3'b000);  // fill, then frozen
    step(1'b1, 1'b1, 3'b010);                        // release
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 3'b010);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 3'b100);  // wrap
    step(1'b1, 1'b0, 3'b010);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 3'b010); // idle, not full
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 3'b010);  // refill
    step(1'b0, 1'b1, 3'b010);                        // reset while full
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 3'b000);

    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(3) != 0)
        p = bin2gray(m_count - $urandom_range(DEPTH));
      else
        p = AW'(0) | 3'($urandom_range(MOD - 1));
      step(($urandom_range(99) == 0) ? 1'b0 : 1'b1, 1'($urandom_range(3) != 0), p);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
